data_align_arb: RTL

DATA_ALIGN_ARB -- requirements
Module: data_align_arb

---
 rtl/data_align_arb.sv | 120 ++++++++++++
 1 files changed

// File: rtl/data_align_arb.sv
// data_align_arb: round-robin packet arbiter that merges N_SRC beat streams
// into the single input of a data aligner, one whole packet at a time.
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | no packet owns the output; pick next requester (one-cycle bubble)
// GRANT | source grant_idx owns the output until its last beat is accepted
module data_align_arb #(
    parameter  int N_SRC  = 4,
    parameter  int DATA_W = 32,
    localparam int KEEP_W = DATA_W / 8,
    localparam int SRC_W  = $clog2(N_SRC)
) (
    input  logic                    clk_i,
    input  logic                    aresetn_i,
    input  logic [N_SRC*DATA_W-1:0] s_data_i,
    input  logic [N_SRC*KEEP_W-1:0] s_keep_i,
    input  logic [N_SRC-1:0]        s_last_i,
    input  logic [N_SRC-1:0]        s_valid_i,
    output logic [N_SRC-1:0]        s_ready_o,
    output logic [DATA_W-1:0]       m_data_o,
    output logic [KEEP_W-1:0]       m_keep_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [SRC_W-1:0]        m_src_o,
    output logic                    busy_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t            state;
    logic [SRC_W-1:0]  ptr;
    logic [SRC_W-1:0]  grant_idx;
    logic [SRC_W-1:0]  grant_inc;
    logic [SRC_W-1:0]  scan_idx;
    logic [SRC_W-1:0]  arb_idx;
    logic              arb_found;
    logic              out_free;
    logic              accept;
    logic [DATA_W-1:0] sel_data;
    logic [KEEP_W-1:0] sel_keep;
    logic              sel_last;

    // Rotating-priority search: first valid source at ptr, ptr+1, ... mod N_SRC
    always_comb begin
        arb_found = 1'b0;
        arb_idx   = '0;
        scan_idx  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            scan_idx = SRC_W'((int'(ptr) + i) % N_SRC);
            if (!arb_found && s_valid_i[scan_idx]) begin
                arb_found = 1'b1;
                arb_idx   = scan_idx;
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle
    assign out_free  = !m_valid_o || m_ready_i;
    assign accept    = (state == GRANT) && s_valid_i[grant_idx] && out_free;
    assign sel_data  = s_data_i[grant_idx*DATA_W +: DATA_W];
    assign sel_keep  = s_keep_i[grant_idx*KEEP_W +: KEEP_W];
    assign sel_last  = s_last_i[grant_idx];
    assign grant_inc = (grant_idx == SRC_W'(N_SRC - 1)) ? '0 : grant_idx + SRC_W'(1);
    assign busy_o    = (state == GRANT);

    // Only the granted source sees ready, and only while in GRANT
    always_comb begin
        s_ready_o = '0;
        if (state == GRANT) begin
            s_ready_o[grant_idx] = out_free;
        end
    end

    // Arbitration state, round-robin pointer and the registered output beat
    always_ff @(posedge clk_i or negedge aresetn_i) begin
        if (!aresetn_i) begin
            state     <= IDLE;
            ptr       <= '0;
            grant_idx <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_keep_o  <= '0;
            m_last_o  <= 1'b0;
            m_src_o   <= '0;
        end else begin
            if (accept) begin
                m_valid_o <= 1'b1;
                m_data_o  <= sel_data;
                m_keep_o  <= sel_keep;
                m_last_o  <= sel_last;
                m_src_o   <= grant_idx;
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (arb_found) begin
                        state     <= GRANT;
                        grant_idx <= arb_idx;
                    end
                end
                GRANT: begin
                    // Grant is held until the last beat, even if valid drops
                    if (accept && sel_last) begin
                        state <= IDLE;
                        ptr   <= grant_inc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
